// File: rtl/mini_mips_pkg.sv
// Shared types and constants for the mini-MIPS multicycle control unit.
package mini_mips_pkg;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  // Opcode field values
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type funct encodings; unlisted funct values fall back to ADD
  localparam logic [2:0] FUNCT_ADD = 3'b000;
  localparam logic [2:0] FUNCT_SUB = 3'b010;
  localparam logic [2:0] FUNCT_AND = 3'b100;
  localparam logic [2:0] FUNCT_OR  = 3'b101;
  localparam logic [2:0] FUNCT_SLT = 3'b111;

  // Sticky error codes
  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL     = 2'd1;
  localparam logic [1:0] ERR_MEM_TIMEOUT = 2'd2;

  // Operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ACLS_NONE,
    ACLS_ADD,
    ACLS_SUB,
    ACLS_RTYPE
  } alu_cls_e;

  // First nonzero error wins; later errors never overwrite it
  function automatic logic [1:0] sticky_err(input logic [1:0] cur, input logic [1:0] nxt);
    return (cur != ERR_NONE) ? cur : nxt;
  endfunction

endpackage

// File: rtl/mini_mips_alu_dec.sv
// Combinational ALU decoder: operation class plus R-type funct -> alu_ctrl.
module mini_mips_alu_dec
  import mini_mips_pkg::*;
(
  input  logic [2:0] funct,
  input  alu_cls_e   alu_cls,
  output logic [2:0] alu_ctrl
);

  // Map the class (and funct for R-type) onto an ALU code
  always_comb begin
    alu_ctrl = ALU_AND;
    case (alu_cls)
      ACLS_ADD: alu_ctrl = ALU_ADD;
      ACLS_SUB: alu_ctrl = ALU_SUB;
      ACLS_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mini_mips_ctrl_fsm.sv
// Multicycle mini-MIPS control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT with
// memory-wait timeout and a sticky error code.
module mini_mips_ctrl_fsm
  import mini_mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src_jump,
  output logic [2:0] alu_ctrl,
  output logic       busy,
  output logic       halted,
  output logic [1:0] err
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  alu_cls_e          alu_cls;
  logic [2:0]        alu_ctrl_dec;

  // The datapath combines pc_write_cond with zero itself
  logic unused_zero;
  assign unused_zero = zero;

  // State, latched opcode, sticky error and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_RTYPE;
      err_q   <= ERR_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // Next state, opcode latch, error update and wait-counter update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    err_d   = err_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_HALT;
          err_d   = sticky_err(err_q, ERR_MEM_TIMEOUT);
        end
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          OP_J:    state_d = S_FETCH;
          OP_HALT: state_d = S_HALT;
          default: begin
            state_d = S_FETCH;
            err_d   = sticky_err(err_q, ERR_ILLEGAL);
          end
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_HALT;
          err_d   = sticky_err(err_q, ERR_MEM_TIMEOUT);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every state entry and only runs while waiting on memory
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + 1'b1;
    end
  end

  // ALU operation class from the latched opcode, only meaningful in EXEC
  always_comb begin
    alu_cls = ACLS_NONE;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_RTYPE:             alu_cls = ACLS_RTYPE;
        OP_ADDI, OP_LW, OP_SW: alu_cls = ACLS_ADD;
        OP_BEQ:               alu_cls = ACLS_SUB;
        default:              alu_cls = ACLS_NONE;
      endcase
    end
  end

  mini_mips_alu_dec u_alu_dec (
    .funct    (funct),
    .alu_cls  (alu_cls),
    .alu_ctrl (alu_ctrl_dec)
  );

  // Moore outputs from state and latched opcode; FETCH strobes gated by mem_ready
  always_comb begin
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src_jump   = 1'b0;
    alu_ctrl      = ALU_AND;
    busy          = (state_q != S_IDLE) && (state_q != S_HALT);
    halted        = (state_q == S_HALT);
    err           = err_q;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        alu_ctrl = ALU_ADD;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        // The opcode is only latched at the end of DECODE, so jumps use the live field
        if (opcode == OP_J) begin
          pc_write    = 1'b1;
          pc_src_jump = 1'b1;
        end
      end
      S_EXEC: begin
        alu_ctrl      = alu_ctrl_dec;
        alu_src       = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW);
        pc_write_cond = (op_q == OP_BEQ);
      end
      S_MEM: begin
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mini_mips_ctrl_fsm.md
MINI_MIPS_CTRL_FSM -- requirements
Module: mini_mips_ctrl_fsm

Interface
REQ-001 SHALL have the parameter MEM_WAIT_MAX, default 15, meaning the maximum number of mem_ready wait cycles before the memory-timeout error.
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have the port start, input, 1 bit: single-cycle pulse that leaves IDLE.
REQ-005 SHALL have the port opcode, input, 4 bits: instruction-register opcode field, valid from DECODE onward.
REQ-006 SHALL have the port funct, input, 3 bits: R-type function field.
REQ-007 SHALL have the port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-008 SHALL have the port zero, input, 1 bit: ALU zero flag, valid in EXEC.
REQ-009 SHALL have the outputs reg_dst, alu_src, mem_to_reg, mem_read, mem_write, reg_write, ir_write, pc_write, pc_write_cond and pc_src_jump, 1 bit each: datapath selects and enables; reg_dst drives the 3-bit destination-register mux select (1 = rd, 0 = rt).
REQ-010 SHALL have the port alu_ctrl, output, 3 bits: ALU operation code.
REQ-011 SHALL have the port busy, output, 1 bit: high in every state except IDLE and HALT.
REQ-012 SHALL have the port halted, output, 1 bit: high in HALT.
REQ-013 SHALL have the port err, output, 2 bits: sticky error code (0 none, 1 illegal opcode, 2 memory timeout).

Function
REQ-014 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 SHALL treat start in IDLE as -> FETCH, and SHALL ignore start in all other states.
REQ-016 FETCH SHALL drive mem_read=1 and alu_ctrl=ADD, and SHALL assert ir_write and pc_write only in the cycle mem_ready=1, then go to DECODE; otherwise it SHALL stay in FETCH.
REQ-017 DECODE SHALL last one cycle: opcodes 0000 (R-type), 0001 (addi), 0010 (lw), 0011 (sw) and 0100 (beq) -> EXEC; 0101 (j) -> FETCH with pc_write=1 and pc_src_jump=1; 1111 (halt) -> HALT; any other opcode -> err=1, then FETCH.
REQ-018 EXEC SHALL decode alu_ctrl from funct for R-type and use ADD for addi/lw/sw and SUB for beq; it SHALL set alu_src=1 for addi/lw/sw.
REQ-019 EXEC SHALL go to WB for R-type and addi, to MEM for lw and sw, and to FETCH for beq with pc_write_cond=1.
REQ-020 MEM SHALL assert mem_read for lw and mem_write for sw until mem_ready=1; on completion lw SHALL go to WB and sw to FETCH.
REQ-021 WB SHALL assert reg_write=1 for exactly one cycle, with reg_dst=1 for R-type and reg_dst=0 for addi/lw, and mem_to_reg=1 only for lw, then go to FETCH.
REQ-022 SHALL latch the opcode in DECODE so that opcode changes after DECODE do not alter the instruction's path.
REQ-023 SHALL hold every output not named for the current state at 0.
REQ-024 With mem_ready tied to 1, latencies from entering FETCH to re-entering FETCH SHALL be: R-type 4, addi 4, lw 5, sw 4, beq 3, j 2 cycles.
REQ-025 SHALL count wait cycles in FETCH and MEM with a saturating counter that resets on each state entry; if MEM_WAIT_MAX cycles pass without mem_ready, the block SHALL set err=2 and go to HALT, with mem_read/mem_write low in HALT.
REQ-026 SHALL ignore mem_ready outside FETCH and MEM.
REQ-027 HALT SHALL be absorbing until reset; start SHALL have no effect there.
REQ-028 err SHALL keep its first nonzero value until reset.

Reset
REQ-029 rst_n=0 SHALL force IDLE, all outputs 0, err=0 and the wait counter 0 immediately, abandoning any in-flight access (including one in MEM).
REQ-030 SHALL deassert reset synchronously with respect to its state effect; the first transition occurs on the first clk edge with rst_n=1.

Structure
REQ-031 The package mini_mips_pkg SHALL hold the state enum, the opcode constants, the alu_ctrl codes (ADD 010, SUB 110, AND 000, OR 001, SLT 111) and the err codes.
REQ-032 SHALL instantiate the sub-module mini_mips_alu_dec (funct + op class -> alu_ctrl), which is purely combinational.
REQ-033 SHALL decode outputs from the state register and latched opcode (Moore outputs), except ir_write/pc_write in FETCH, which are gated by mem_ready.

Verification
REQ-034 The bench SHALL cover: reset, start, mem_ready=1, R-type opcode 0000 with funct 010 -> FETCH/DECODE/EXEC/WB; reg_write=1 and reg_dst=1 in cycle 4 only.
REQ-035 The bench SHALL cover: lw with mem_ready low for 3 MEM cycles -> mem_read held for 4 MEM cycles, then WB with reg_dst=0 and mem_to_reg=1.
REQ-036 The bench SHALL cover: beq with zero=1 -> pc_write_cond=1 in EXEC, with no reg_write anywhere.
REQ-037 The bench SHALL cover: opcode 1010 -> err=1 after DECODE, return to FETCH, and err still 1 after 10 further instructions.
REQ-038 The bench SHALL cover: sw with mem_ready held 0 for 16 cycles -> err=2 and halted=1, with mem_write=0 afterwards.
REQ-039 The bench SHALL cover: rst_n pulsed low mid-MEM -> all outputs 0 in the same cycle and state IDLE; a later start restarts from FETCH.
